// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encodings and default operand width
// for the serial arithmetic units.
package arith_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 4;

endpackage : arith_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bin with borrow-out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~A & Bin) | (B & Bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (A - B - Bin), LSB first, with start/busy/done
// handshake; the result registers hold their value until the next completion.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_c;
  logic [WIDTH-1:0] w_d_next;

  full_subtractor u_cell (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Bin  (r_c),
    .D    (w_d),
    .Bout (w_c)
  );

  // New difference bit enters at the MSB so the LSB-first stream lands in place.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_d_next = w_d;
    end else begin : g_wn
      assign w_d_next = {w_d, r_d[WIDTH-1:1]};
    end
  endgenerate

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      Diff    <= '0;
      Bout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_c     <= Bin;
            r_cnt   <= '0;
            r_d     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_d   <= w_d_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            Diff    <= w_d_next;
            Bout    <= w_c;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule : serial_subtractor
